rr_burst_scheduler: RTL and testbench
=====================================

Name: rr_burst_scheduler

Overview:
- Shares one burst-oriented resource port (e.g. a memory bank or PE input port) among NUM_REQS requesters.
- Each requester asks for an N-beat burst. The block picks one owner round-robin and holds that grant for the whole burst, counting beats against the resource's ready signal.
- It then re-arbitrates with zero bubble when another request is pending.
- Sits between requester front-ends and the shared resource.

Parameters:
- NUM_REQS, 5, number of requesters (>=2).
- LEN_W, 4, width of per-request burst length field. Encoding is beats-1, so max burst = 2^LEN_W beats.
- IDX_W, $clog2(NUM_REQS), width of the owner index (derived; not overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- reqs  in  NUM_REQS  per-requester burst request; level, held until done.
- req_len  in  NUM_REQS*LEN_W  burst length (beats-1) per requester; slice i = [i*LEN_W +: LEN_W].
- res_ready  in  1  resource accepts the current beat this cycle.
- grants  out  NUM_REQS  one-hot owner of the resource; all-zero when idle.
- owner_idx  out  IDX_W  binary index of the owner; 0 when idle.
- res_valid  out  1  beat offered to the resource (= busy).
- beat_cnt  out  LEN_W  index of the current beat within the burst.
- last  out  1  current beat is the final beat of the burst.
- done  out  NUM_REQS  one-hot, one-cycle pulse on the final beat handshake.

Behaviour:
- Reset values: state=IDLE, grants=0, owner_idx=0, res_valid=0, beat_cnt=0, len_q=0, done=0. Priority pointer P=one-hot bit0 (requester 0 highest).
- Reset mid-burst aborts the burst immediately. No done pulse is produced.
- Arbitration (combinational pick):
  - The winner is the first set bit of the eligible requests, scanning circularly from P upward.
  - On each grant, P becomes the winner rotated left by 1, so the winner becomes lowest priority.
  - P is unchanged when there is no grant.
- FSM state IDLE:
  - If any reqs bit is set in cycle t, the winner is registered into grants/owner_idx at edge t+1, and state becomes BURST.
  - len_q captures req_len[winner] at that same edge; beat_cnt=0.
  - Grant latency is 1 cycle from request.
- FSM state BURST:
  - res_valid=1.
  - When res_ready=1 and beat_cnt!=len_q: beat_cnt increments.
  - When res_ready=0: all registers hold.
  - last = (beat_cnt==len_q), combinational from registers.
- Completion cycle (last && res_ready):
  - done[owner]=1 combinationally in this cycle.
  - Arbitration runs over reqs & ~grants, i.e. the finishing owner is masked.
  - If a winner exists: grants, owner_idx and len_q load the new owner at the next edge; beat_cnt=0; state stays BURST. This is the zero-bubble back-to-back handoff.
  - If no winner: state goes to IDLE and grants=0.
  - A requester still asserting reqs after its done is re-granted only once it is eligible again (next arbitration).
- Single-beat burst: with len_q=0, the first accepted beat is last; done pulses on that beat.
- Requester deasserting reqs mid-burst is ignored; the burst runs to completion.
- req_len changes after grant are ignored (len_q is latched).
- Maximum burst: beat_cnt reaches 2^LEN_W-1 without overflow; no wrap within a burst.
- Invariants: grants is always one-hot or zero; at most one done bit is set per cycle.
- All outputs except last and done are registered.

Decomposition:
- Shared package (sched_pkg):
  - state enum {IDLE, BURST};
  - default NUM_REQS/LEN_W localparams;
  - function onehot_to_idx.
- Sub-module rr_pick:
  - purely combinational circular priority picker;
  - inputs: eligible requests, pointer P;
  - outputs: one-hot winner and a valid flag.
- The top level holds the FSM, pointer, length latch and beat counter.

Test Plan:
- Reset, then reqs=5'b00100 with len 2, res_ready=1 → grants=5'b00100 at cycle +1. last and done[2] occur at the 3rd beat, then IDLE with grants=0.
- reqs=5'b11111, all len 0, res_ready=1 held → grant order 0,1,2,3,4,0. There is one done per cycle with no idle gap.
- Owner 1 with len 3, res_ready toggling 1,0,1,0,… → beat_cnt advances only on ready cycles. done[1] occurs after exactly 4 ready cycles.
- Owner 3 finishing while reqs=5'b01000 (only itself) → goes to IDLE for one cycle, then re-granted. It is not granted in the completion cycle.
- Assert reset mid-burst (beat_cnt=2) → next cycle all outputs are 0, no done pulse, and P=bit0. Then reqs=5'b10001 → requester 0 is granted.
- Change req_len[owner] and drop reqs[owner] mid-burst → burst length equals the latched value and completes normally.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and helpers for the round-robin burst scheduler.
// Holds the FSM state encoding and the one-hot to binary index conversion.
package sched_pkg;

    localparam int DEF_NUM_REQS = 5;
    localparam int DEF_LEN_W    = 4;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    // Inputs wider than a vector's own width are zero-extended by the caller.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first eligible bit at or above the
// one-hot pointer, wrapping around to bit 0.
module rr_pick #(
    parameter int N = 5
) (
    input  logic [N-1:0] eligible,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] winner,
    output logic         valid
);

    logic [2*N-1:0] req2;
    logic [2*N-1:0] masked;
    logic [2*N-1:0] first;

    // The doubled request vector lets a plain lowest-set-bit search handle the
    // wrap: the lower copy is masked below the pointer, the upper copy is not.
    always_comb begin
        req2   = {eligible, eligible};
        masked = req2 & ~({{N{1'b0}}, ptr} - (2*N)'(1));
        first  = masked & (~masked + (2*N)'(1));
        winner = first[N-1:0] | first[2*N-1:N];
        valid  = |eligible;
    end

endmodule

// File: rtl/rr_burst_scheduler.sv
// Shares one burst resource among NUM_REQS requesters: round-robin owner
// selection, grant held for the whole burst, zero-bubble handoff on completion.
module rr_burst_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_REQS = DEF_NUM_REQS,
    parameter int LEN_W    = DEF_LEN_W,
    localparam int IDX_W   = $clog2(NUM_REQS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       reqs,
    input  logic [NUM_REQS*LEN_W-1:0] req_len,
    input  logic                      res_ready,
    output logic [NUM_REQS-1:0]       grants,
    output logic [IDX_W-1:0]          owner_idx,
    output logic                      res_valid,
    output logic [LEN_W-1:0]          beat_cnt,
    output logic                      last,
    output logic [NUM_REQS-1:0]       done
);

    state_t                state_q, state_d;
    logic [NUM_REQS-1:0]   grants_q, grants_d;
    logic [IDX_W-1:0]      owner_idx_q, owner_idx_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [NUM_REQS-1:0]   ptr_q, ptr_d;

    logic [NUM_REQS-1:0]   eligible;
    logic [NUM_REQS-1:0]   winner;
    logic                  pick_valid;
    logic [IDX_W-1:0]      win_idx;
    logic                  finish;
    logic                  load;

    rr_pick #(
        .N (NUM_REQS)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .winner   (winner),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grants_q    <= '0;
            owner_idx_q <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            ptr_q       <= NUM_REQS'(1);
        end else begin
            state_q     <= state_d;
            grants_q    <= grants_d;
            owner_idx_q <= owner_idx_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    // Output / arbitration-input decode from registered state.
    always_comb begin
        last     = (state_q == BURST) && (beat_cnt_q == len_q);
        finish   = last && res_ready;
        done     = finish ? grants_q : '0;
        // The finishing owner is masked so a held request cannot be re-granted
        // back-to-back to itself.
        eligible = '0;
        if (state_q == IDLE) eligible = reqs;
        else if (finish)     eligible = reqs & ~grants_q;
        load     = pick_valid && ((state_q == IDLE) || finish);
        win_idx  = IDX_W'(onehot_to_idx(32'(winner)));
    end

    always_comb begin
        state_d     = state_q;
        grants_d    = grants_q;
        owner_idx_d = owner_idx_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        ptr_d       = ptr_q;
        if (load) begin
            state_d     = BURST;
            grants_d    = winner;
            owner_idx_d = win_idx;
            len_d       = req_len[int'(win_idx)*LEN_W +: LEN_W];
            beat_cnt_d  = '0;
            ptr_d       = {winner[NUM_REQS-2:0], winner[NUM_REQS-1]};
        end else if (finish) begin
            state_d     = IDLE;
            grants_d    = '0;
            owner_idx_d = '0;
            len_d       = '0;
            beat_cnt_d  = '0;
        end else if ((state_q == BURST) && res_ready) begin
            beat_cnt_d  = beat_cnt_q + LEN_W'(1);
        end
    end

    assign grants    = grants_q;
    assign owner_idx = owner_idx_q;
    assign res_valid = (state_q == BURST);
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Directed bench for rr_burst_scheduler: linear stimulus, hand-computed
// expectations checked with immediate assertions 1ns after each rising edge.
module tb_rr_burst_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  reqs;
    logic [19:0] req_len;
    logic        res_ready;
    logic [4:0]  grants;
    logic [2:0]  owner_idx;
    logic        res_valid;
    logic [3:0]  beat_cnt;
    logic        last;
    logic [4:0]  done;

    int npass = 0;
    int ntotal = 0;

    rr_burst_scheduler #(
        .NUM_REQS (5),
        .LEN_W    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reqs      (reqs),
        .req_len   (req_len),
        .res_ready (res_ready),
        .grants    (grants),
        .owner_idx (owner_idx),
        .res_valid (res_valid),
        .beat_cnt  (beat_cnt),
        .last      (last),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grants"}, 32'(grants), 32'h0);
        chk({tag, "_owner"}, 32'(owner_idx), 32'h0);
        chk({tag, "_valid"}, 32'(res_valid), 32'h0);
        chk({tag, "_beat"}, 32'(beat_cnt), 32'h0);
        chk({tag, "_last"}, 32'(last), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
    endtask

    initial begin
        reset = 1'b1; reqs = '0; req_len = '0; res_ready = 1'b0;
        tick(); tick();
        chk_idle("reset");

        // Single owner 2, length 2 (three beats), request dropped after grant.
        reset = 1'b0; reqs = 5'b00100; req_len[8 +: 4] = 4'd2; res_ready = 1'b1;
        tick();
        chk("s1_grant", 32'(grants), 32'h04);
        chk("s1_owner", 32'(owner_idx), 32'd2);
        chk("s1_valid", 32'(res_valid), 32'h1);
        chk("s1_beat0", 32'(beat_cnt), 32'd0);
        chk("s1_last0", 32'(last), 32'h0);
        reqs = '0;
        tick();
        chk("s1_beat1", 32'(beat_cnt), 32'd1);
        tick();
        chk("s1_beat2", 32'(beat_cnt), 32'd2);
        chk("s1_last2", 32'(last), 32'h1);
        chk("s1_done", 32'(done), 32'h04);
        tick();
        chk_idle("s1_idle");

        // All five requesting with single-beat bursts: strict rotation, no gap.
        reset = 1'b1; tick(); reset = 1'b0;
        reqs = 5'b11111; req_len = '0; res_ready = 1'b1;
        tick();
        chk("s2_g0", 32'(grants), 32'h01);
        chk("s2_d0", 32'(done), 32'h01);
        tick();
        chk("s2_g1", 32'(grants), 32'h02);
        chk("s2_d1", 32'(done), 32'h02);
        tick();
        chk("s2_g2", 32'(grants), 32'h04);
        tick();
        chk("s2_g3", 32'(grants), 32'h08);
        chk("s2_o3", 32'(owner_idx), 32'd3);
        tick();
        chk("s2_g4", 32'(grants), 32'h10);
        chk("s2_d4", 32'(done), 32'h10);
        tick();
        chk("s2_g5", 32'(grants), 32'h01);
        chk("s2_o5", 32'(owner_idx), 32'd0);
        reqs = '0;
        tick();
        chk("s2_idle", 32'(grants), 32'h0);

        // Owner 1, length 3, ready toggling: beat advances only on ready.
        reqs = 5'b00010; req_len[4 +: 4] = 4'd3; res_ready = 1'b1;
        tick();
        chk("s3_grant", 32'(grants), 32'h02);
        reqs = '0;
        tick();
        chk("s3_b1", 32'(beat_cnt), 32'd1);
        res_ready = 1'b0;
        tick();
        chk("s3_hold1", 32'(beat_cnt), 32'd1);
        res_ready = 1'b1;
        tick();
        chk("s3_b2", 32'(beat_cnt), 32'd2);
        res_ready = 1'b0;
        tick();
        chk("s3_hold2", 32'(beat_cnt), 32'd2);
        res_ready = 1'b1;
        tick();
        chk("s3_b3", 32'(beat_cnt), 32'd3);
        res_ready = 1'b0; #1;
        chk("s3_last_nrdy", 32'(last), 32'h1);
        chk("s3_done_nrdy", 32'(done), 32'h0);
        res_ready = 1'b1; #1;
        chk("s3_done", 32'(done), 32'h02);
        tick();
        chk("s3_idle", 32'(grants), 32'h0);

        // Owner 3 alone and still requesting: one idle cycle, then re-grant.
        reqs = 5'b01000; req_len[12 +: 4] = 4'd0;
        tick();
        chk("s4_grant", 32'(grants), 32'h08);
        chk("s4_done", 32'(done), 32'h08);
        tick();
        chk("s4_gap", 32'(grants), 32'h0);
        chk("s4_gap_valid", 32'(res_valid), 32'h0);
        tick();
        chk("s4_regrant", 32'(grants), 32'h08);
        reqs = '0;
        tick();
        chk("s4_idle", 32'(grants), 32'h0);

        // Reset mid-burst at beat 2: abort, no done, pointer back to bit 0.
        reqs = 5'b00001; req_len[0 +: 4] = 4'd5;
        tick();
        chk("s5_grant", 32'(grants), 32'h01);
        reqs = '0;
        tick(); tick();
        chk("s5_beat2", 32'(beat_cnt), 32'd2);
        reset = 1'b1;
        tick();
        chk_idle("s5_reset");
        reset = 1'b0; reqs = 5'b10001;
        tick();
        chk("s5_ptr", 32'(grants), 32'h01);
        chk("s5_len", 32'(beat_cnt), 32'd0);

        // Length change and request drop mid-burst: latched length 5 wins.
        req_len[0 +: 4] = 4'd1; reqs = '0;
        tick();
        chk("s6_b1", 32'(beat_cnt), 32'd1);
        chk("s6_nolast1", 32'(last), 32'h0);
        tick(); tick(); tick();
        chk("s6_b4", 32'(beat_cnt), 32'd4);
        chk("s6_nolast4", 32'(last), 32'h0);
        tick();
        chk("s6_b5", 32'(beat_cnt), 32'd5);
        chk("s6_last", 32'(last), 32'h1);
        chk("s6_done", 32'(done), 32'h01);
        tick();
        chk("s6_idle", 32'(grants), 32'h0);

        // Maximum burst on owner 4: beat counter reaches 15 without wrapping.
        reqs = 5'b10000; req_len[16 +: 4] = 4'd15;
        tick();
        chk("s7_grant", 32'(grants), 32'h10);
        chk("s7_owner", 32'(owner_idx), 32'd4);
        reqs = '0;
        for (int i = 0; i < 14; i++) tick();
        chk("s7_b14", 32'(beat_cnt), 32'd14);
        chk("s7_nolast", 32'(last), 32'h0);
        tick();
        chk("s7_b15", 32'(beat_cnt), 32'd15);
        chk("s7_last", 32'(last), 32'h1);
        chk("s7_done", 32'(done), 32'h10);
        tick();
        chk_idle("s7_idle");

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
